// File: rtl/dp2_bias_requant.sv
// Bias-add and int8 requantization stage fed by the depthwise-pointwise layer-2 bias ROM.
// Define DP2_RELU_EN to clamp the result to [0,127] instead of signed [-128,127].
module dp2_bias_requant #(
  parameter int ACC_W      = 24,
  parameter int NUM_CH     = 64,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    acc_valid,
  output logic                    acc_ready,
  input  logic signed [ACC_W-1:0] acc_data,
  input  logic                    acc_last,
  output logic [5:0]              bias_addr,
  input  logic signed [7:0]       bias_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [7:0]       out_data,
  output logic                    out_last,
  output logic                    align_err
);

  localparam int SW      = ACC_W + 1;
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic [5:0]          LAST_CH = 6'(NUM_CH - 1);
  localparam logic signed [SW:0]  RND     = (OUT_SHIFT > 0) ? ((SW+1)'(1) <<< RND_POS) : '0;
  localparam logic signed [SW:0]  SAT_HI  = (SW+1)'(127);
  localparam logic signed [SW:0]  SAT_LO  = (SW+1)'(-128);

  logic [5:0]           ch_cnt;
  logic                 s1_valid;
  logic signed [SW-1:0] s1_sum;
  logic                 s1_last;

  logic                 advance;
  logic                 accept;
  logic                 at_last;
  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] sum_nxt;
  logic signed [SW:0]   rnd_sum;
  logic signed [SW:0]   shifted;
  logic signed [7:0]    sat;

  assign advance   = !out_valid || out_ready;
  assign acc_ready = rst_n && advance;
  assign accept    = acc_valid && acc_ready && !clear;
  assign at_last   = (ch_cnt == LAST_CH);
  assign bias_addr = ch_cnt;

  assign acc_ext  = SW'(acc_data);
  assign bias_ext = SW'(bias_data) <<< BIAS_SHIFT;
  assign sum_nxt  = acc_ext + bias_ext;

  // Extra guard bit keeps the rounding add from wrapping at the top of the range.
  assign rnd_sum = (SW+1)'(s1_sum) + RND;
  assign shifted = rnd_sum >>> OUT_SHIFT;

  always_comb begin
    sat = shifted[7:0];
`ifdef DP2_RELU_EN
    if (shifted[SW])
      sat = 8'sh00;
    else if (shifted > SAT_HI)
      sat = 8'sh7f;
`else
    if (shifted > SAT_HI)
      sat = 8'sh7f;
    else if (shifted < SAT_LO)
      sat = 8'sh80;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_cnt    <= '0;
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      align_err <= 1'b0;
    end else if (clear) begin
      ch_cnt    <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Mismatch is only flagged; the counter keeps its own sequence.
      if (accept && (acc_last != at_last))
        align_err <= 1'b1;
      if (advance) begin
        s1_valid  <= accept;
        out_valid <= s1_valid;
        if (accept) begin
          s1_sum  <= sum_nxt;
          s1_last <= at_last;
          ch_cnt  <= at_last ? 6'd0 : ch_cnt + 6'd1;
        end
        if (s1_valid) begin
          out_data <= sat;
          out_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_dp2_bias_requant.sv
// Self-checking bench for dp2_bias_requant: directed steps plus random data scored
// against an arithmetic reference model and a ROM image held in the bench.
module tb_dp2_bias_requant;

  localparam int ACC_W = 24;
  localparam int NCH   = 64;
  localparam int BS    = 4;
  localparam int OS    = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              acc_valid = 1'b0;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_data = '0;
  logic              acc_last = 1'b0;
  logic [5:0]        bias_addr;
  logic [7:0]        bias_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              out_last;
  logic              align_err;

  logic [7:0] bias_rom [NCH];
  assign bias_data = bias_rom[bias_addr];

  dp2_bias_requant #(.ACC_W(ACC_W), .NUM_CH(NCH), .BIAS_SHIFT(BS), .OUT_SHIFT(OS)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_last(acc_last),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; bit l; } exp_t;
  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   mch = 0;
  bit   malign = 0;
  bit   mv1 = 0;
  bit   mv2 = 0;
  int   nlast = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [7:0] ref_out(input int acc, input int b);
    longint s, r;
    s = longint'(acc) + longint'(b) * (2 ** BS);
    r = (OS > 0) ? fdiv(s + (2 ** OS) / 2, 2 ** OS) : s;
`ifdef DP2_RELU_EN
    if (r < 0) r = 0;
    if (r > 127) r = 127;
`else
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`endif
    return 8'(r);
  endfunction

  // One clock: check visible state against the model, then advance the model with the edge.
  task automatic tick(output bit accepted);
    bit adv, hs;
    exp_t e;
    #2;
    adv = !mv2 || out_ready;
    chk("acc_ready", 32'(acc_ready), 32'(rst_n && adv));
    chk("out_valid", 32'(out_valid), 32'(mv2));
    chk("bias_addr", 32'(bias_addr), 32'(mch));
    chk("align_err", 32'(align_err), 32'(malign));
    if (mv2 && q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_last", 32'(out_last), 32'(q[0].l));
    end
    accepted = rst_n && !clear && acc_valid && adv;
    hs = mv2 && out_ready;
    if (hs && q.size() > 0) begin
      if (q[0].l) nlast++;
      void'(q.pop_front());
    end
    if (accepted) begin
      e.d = ref_out(int'($signed(acc_data)), int'($signed(bias_rom[mch])));
      e.l = (mch == NCH - 1);
      q.push_back(e);
      if (acc_last != (mch == NCH - 1)) malign = 1;
      mch = (mch + 1) % NCH;
    end
    if (!rst_n) begin
      mv1 = 0; mv2 = 0; mch = 0; malign = 0; q.delete();
    end else if (clear) begin
      mv1 = 0; mv2 = 0; mch = 0; q.delete();
    end else if (adv) begin
      mv2 = mv1; mv1 = accepted;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    acc_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  task automatic send(input int acc, input bit last);
    bit a = 0;
    int n = 0;
    acc_valid = 1'b1;
    acc_data = 24'(acc);
    acc_last = last;
    while (!a && n < 200) begin
      tick(a);
      n++;
    end
    if (!a) begin
      nchk++; nfail++;
      $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
    end
  endtask

  function automatic int rnd_acc();
    logic [31:0] r;
    r = $urandom;
    return int'($signed(r[23:0])) >>> r[27:24];
  endfunction

  task automatic new_beat();
    acc_data = 24'(rnd_acc());
    acc_last = (mch == NCH - 1);
  endtask

  initial begin
    bit a;
    for (int i = 0; i < NCH; i++) bias_rom[i] = 8'($urandom);
    bias_rom[0] = 8'hB6;
    bias_rom[1] = 8'h00;
    bias_rom[2] = 8'h00;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_align_err", 32'(align_err), 32'(0));
    chk("rst_bias_addr", 32'(bias_addr), 32'(0));

    // Basic path: channel 0, bias -74
    send(2000, 1'b0);
    idle(1);
    chk("basic_data", 32'(out_data), 32'(8'd13));
    chk("basic_last", 32'(out_last), 32'(0));
    idle(1);

    send(100000, 1'b0);
    idle(1);
    chk("sat_pos", 32'(out_data), 32'(8'd127));
    idle(1);
    send(-5000, 1'b0);
    idle(1);
`ifdef DP2_RELU_EN
    chk("sat_neg", 32'(out_data), 32'(8'd0));
`else
    chk("sat_neg", 32'(out_data), 32'(8'hB2));
`endif
    idle(1);

    clear = 1'b1; tick(a); clear = 1'b0;

    // Channel sequencing across two pixels and a bit
    nlast = 0;
    for (int i = 0; i < 130; i++) send(rnd_acc(), (i % 64) == 63);
    idle(3);
    chk("last_count", 32'(nlast), 32'(2));
    chk("seq_align", 32'(align_err), 32'(0));
    chk("seq_addr", 32'(bias_addr), 32'(2));

    // Backpressure: 10-cycle stall mid-stream, then random ready and valid
    acc_valid = 1'b1;
    new_beat();
    for (int c = 0; c < 50; c++) begin
      out_ready = !(c >= 20 && c < 30);
      tick(a);
      if (c >= 22 && c < 30) chk("stall_ready", 32'(acc_ready), 32'(0));
      if (a) new_beat();
    end
    for (int c = 0; c < 120; c++) begin
      out_ready = 1'($urandom);
      if (!acc_valid || a) begin
        acc_valid = 1'($urandom);
        new_beat();
      end
      tick(a);
    end
    out_ready = 1'b1;
    idle(4);

    // Misaligned acc_last on channel 5
    clear = 1'b1; tick(a); clear = 1'b0;
    for (int i = 0; i < 6; i++) send(rnd_acc(), i == 5);
    acc_valid = 1'b0;
    #2;
    chk("misalign_set", 32'(align_err), 32'(1));
    #(-0);
    for (int i = 0; i < 200; i++) begin
      new_beat();
      send(int'($signed(acc_data)), acc_last);
    end
    idle(3);
    chk("misalign_sticky", 32'(align_err), 32'(1));

    // clear with a beat in flight
    send(rnd_acc(), 1'b0);
    clear = 1'b1;
    acc_valid = 1'b1;
    acc_data = 24'(rnd_acc());
    tick(a);
    clear = 1'b0;
    idle(3);
    chk("clear_no_valid", 32'(out_valid), 32'(0));
    chk("clear_addr", 32'(bias_addr), 32'(0));
    chk("clear_align_kept", 32'(align_err), 32'(1));
    for (int i = 0; i < 10; i++) send(rnd_acc(), 1'b0);

    // Reset mid-stream
    acc_valid = 1'b1;
    rst_n = 1'b0;
    tick(a);
    tick(a);
    acc_valid = 1'b0;
    rst_n = 1'b1;
    chk("mrst_out_valid", 32'(out_valid), 32'(0));
    chk("mrst_out_data", 32'(out_data), 32'(0));
    chk("mrst_out_last", 32'(out_last), 32'(0));
    chk("mrst_align_err", 32'(align_err), 32'(0));
    chk("mrst_bias_addr", 32'(bias_addr), 32'(0));
    idle(2);
    send(2000, 1'b0);
    idle(1);
    chk("post_rst_data", 32'(out_data), 32'(8'd13));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
